// File: rtl/conv_controller_pkg.sv
// Shared types for the convolution datapath: data word, coordinate views and
// the sequencer state encoding.
package tpu_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int MATRIX_DIM_DEF = 16;
    localparam int CONV_DIM_DEF   = 3;

    typedef logic [DATA_WIDTH-1:0] data_t;

    // Coordinates at the default bank sizes; x = row, y = column
    typedef struct packed {
        logic [$clog2(CONV_DIM_DEF)-1:0] x;
        logic [$clog2(CONV_DIM_DEF)-1:0] y;
    } conv_coord_t;

    typedef struct packed {
        logic [$clog2(MATRIX_DIM_DEF)-1:0] x;
        logic [$clog2(MATRIX_DIM_DEF)-1:0] y;
    } matrix_coord_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_M,
        COMPUTE,
        CAPTURE,
        EMIT,
        FINISH
    } ctrl_state_t;

endpackage

// File: rtl/conv_controller_if.sv
// Load stream, register-bank, MAC and result-stream signals of the sequencer.
// master = controller side, slave = datapath/environment side.
interface conv_controller_if
    import tpu_pkg::*;
#(
    parameter int MATRIX_DIM = MATRIX_DIM_DEF,
    parameter int CONV_DIM   = CONV_DIM_DEF
);
    localparam int KAW = 2*$clog2(CONV_DIM);
    localparam int MAW = 2*$clog2(MATRIX_DIM);

    logic           start;
    logic           in_valid;
    logic           in_ready;
    data_t          data_in;
    data_t          wdata;
    logic           kernal_we;
    logic           matrix_we;
    logic [KAW-1:0] k_addr;
    logic [MAW-1:0] m_addr;
    logic           mac_clr;
    logic           mac_en;
    data_t          mac_sum;
    logic           out_valid;
    logic           out_ready;
    data_t          out_data;
    logic           busy;
    logic           done;

    modport master (
        input  start, in_valid, data_in, mac_sum, out_ready,
        output in_ready, wdata, kernal_we, matrix_we, k_addr, m_addr,
               mac_clr, mac_en, out_valid, out_data, busy, done
    );

    modport slave (
        output start, in_valid, data_in, mac_sum, out_ready,
        input  in_ready, wdata, kernal_we, matrix_we, k_addr, m_addr,
               mac_clr, mac_en, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/conv_controller_addr_gen.sv
// Row-major 2-D coordinate counter. i_max sets the wrap point of both axes so
// one instance can walk a smaller square than DIM allows.
module conv_addr_gen #(
    parameter int DIM = 4,
    parameter int AW  = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [AW-1:0] i_max,
    output logic [AW-1:0] o_x,
    output logic [AW-1:0] o_y,
    output logic          o_last
);

    logic [AW-1:0] r_x;
    logic [AW-1:0] r_y;

    // y advances fastest, x steps when y wraps; clear wins over enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (r_y == i_max) begin
                r_y <= '0;
                r_x <= (r_x == i_max) ? '0 : r_x + 1'b1;
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == i_max) && (r_y == i_max);

endmodule

// File: rtl/conv_controller.sv
// Convolution sequencer: loads kernel and matrix banks over one stream, then
// walks every no-padding output position driving taps and the shared MAC.
//
// state   | meaning
// IDLE    | waiting for start, all strobes low
// LOAD_K  | accepting kernel words, row-major
// LOAD_M  | accepting matrix words, row-major
// COMPUTE | one MAC tap per cycle, clear on tap (0,0)
// CAPTURE | MAC settled, register mac_sum
// EMIT    | result held on out_data until accepted
// FINISH  | one-cycle done pulse
module conv_controller
    import tpu_pkg::*;
#(
    parameter int MATRIX_DIM = MATRIX_DIM_DEF,
    parameter int CONV_DIM   = CONV_DIM_DEF
) (
    input  logic clk,
    input  logic rst,
    conv_controller_if.master bus
);

    localparam int OUT_DIM = MATRIX_DIM - CONV_DIM + 1;
    localparam int KW      = $clog2(CONV_DIM);
    localparam int MW      = $clog2(MATRIX_DIM);
    localparam int BW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    ctrl_state_t r_state;
    logic        r_in_ready;
    logic        r_mac_en;
    logic        r_out_valid;
    logic        r_busy;
    logic        r_done;
    data_t       r_out_data;

    logic          w_accept;
    logic          w_ld_clr;
    logic          w_ld_last;
    logic [MW-1:0] w_ld_max;
    logic [MW-1:0] w_ld_x;
    logic [MW-1:0] w_ld_y;
    logic          w_walk_clr;
    logic          w_tap_last;
    logic [KW-1:0] w_tap_x;
    logic [KW-1:0] w_tap_y;
    logic          w_base_en;
    logic          w_base_last;
    logic [BW-1:0] w_base_x;
    logic [BW-1:0] w_base_y;
    logic [MW-1:0] w_sum_x;
    logic [MW-1:0] w_sum_y;
    logic [2*KW-1:0] w_k_addr;
    logic [2*MW-1:0] w_m_addr;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_ld_clr   = ((r_state == IDLE) && bus.start) ||
                        ((r_state == LOAD_K) && w_accept && w_ld_last);
    // The load counter covers only the kernel square during LOAD_K
    assign w_ld_max   = (r_state == LOAD_K) ? MW'(CONV_DIM - 1) : MW'(MATRIX_DIM - 1);
    assign w_walk_clr = (r_state == LOAD_M) && w_accept && w_ld_last;
    assign w_base_en  = (r_state == EMIT) && bus.out_ready;

    conv_addr_gen #(.DIM(MATRIX_DIM), .AW(MW)) u_load (
        .clk(clk), .rst(rst), .i_clr(w_ld_clr), .i_en(w_accept),
        .i_max(w_ld_max), .o_x(w_ld_x), .o_y(w_ld_y), .o_last(w_ld_last)
    );

    // Tap wraps back to (0,0) on its own after the last tap
    conv_addr_gen #(.DIM(CONV_DIM), .AW(KW)) u_tap (
        .clk(clk), .rst(rst), .i_clr(w_walk_clr), .i_en(r_state == COMPUTE),
        .i_max(KW'(CONV_DIM - 1)), .o_x(w_tap_x), .o_y(w_tap_y), .o_last(w_tap_last)
    );

    conv_addr_gen #(.DIM(OUT_DIM), .AW(BW)) u_base (
        .clk(clk), .rst(rst), .i_clr(w_walk_clr), .i_en(w_base_en),
        .i_max(BW'(OUT_DIM - 1)), .o_x(w_base_x), .o_y(w_base_y), .o_last(w_base_last)
    );

    assign w_sum_x = MW'(w_base_x) + MW'(w_tap_x);
    assign w_sum_y = MW'(w_base_y) + MW'(w_tap_y);

    // Sequencer state and registered handshake/strobe flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_mac_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= LOAD_K;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD_K: begin
                    if (w_accept && w_ld_last) r_state <= LOAD_M;
                end
                LOAD_M: begin
                    if (w_accept && w_ld_last) begin
                        r_state    <= COMPUTE;
                        r_in_ready <= 1'b0;
                        r_mac_en   <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (w_tap_last) begin
                        r_state  <= CAPTURE;
                        r_mac_en <= 1'b0;
                    end
                end
                CAPTURE: begin
                    r_out_data  <= bus.mac_sum;
                    r_out_valid <= 1'b1;
                    r_state     <= EMIT;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_base_last) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= COMPUTE;
                            r_mac_en <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address muxing: load counter while loading, tap/base+tap while computing
    always_comb begin
        w_k_addr = '0;
        w_m_addr = '0;
        case (r_state)
            LOAD_K:  w_k_addr = {w_ld_x[KW-1:0], w_ld_y[KW-1:0]};
            LOAD_M:  w_m_addr = {w_ld_x, w_ld_y};
            COMPUTE: begin
                w_k_addr = {w_tap_x, w_tap_y};
                w_m_addr = {w_sum_x, w_sum_y};
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.wdata     = bus.data_in;
    assign bus.kernal_we = w_accept && (r_state == LOAD_K);
    assign bus.matrix_we = w_accept && (r_state == LOAD_M);
    assign bus.k_addr    = w_k_addr;
    assign bus.m_addr    = w_m_addr;
    assign bus.mac_en    = r_mac_en;
    assign bus.mac_clr   = r_mac_en && (w_tap_x == '0) && (w_tap_y == '0);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: models the register banks and a 1-cycle MAC,
// and checks every result against a direct sum over the kernel window.
`timescale 1ns/1ps
module tb_conv_controller;
    import tpu_pkg::*;

    localparam int MD   = 4;
    localparam int CD   = 2;
    localparam int OD   = MD - CD + 1;
    localparam int NOUT = OD * OD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    conv_controller_if #(.MATRIX_DIM(MD), .CONV_DIM(CD)) bus ();

    conv_controller #(.MATRIX_DIM(MD), .CONV_DIM(CD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Stimulus and reference
    data_t k_in[CD*CD];
    data_t m_in[MD*MD];

    function automatic data_t ref_out(input int bx, input int by);
        data_t s = '0;
        for (int i = 0; i < CD; i++)
            for (int j = 0; j < CD; j++)
                s += k_in[i*CD+j] * m_in[(bx+i)*MD + (by+j)];
        return s;
    endfunction

    // Environment: banks and MAC, result visible one edge after enable
    data_t kb[CD*CD];
    data_t mb[MD*MD];
    data_t acc = '0;

    always @(posedge clk) begin
        if (bus.kernal_we) kb[bus.k_addr] <= bus.wdata;
        if (bus.matrix_we) mb[bus.m_addr] <= bus.wdata;
        if (bus.mac_en) acc <= (bus.mac_clr ? '0 : acc) + kb[bus.k_addr] * mb[bus.m_addr];
    end
    assign bus.mac_sum = acc;

    // Mid-cycle monitor
    int cyc = 0, kwe_cnt = 0, mwe_cnt = 0, addr_bad = 0, clr_bad = 0;
    int done_cnt = 0, db_bad = 0, rise_cnt = 0, tim_bad = 0;
    int last_rise = -1, mon_job = -1;
    bit prev_ov = 1'b0, prev_done = 1'b0;
    int job_id = 0;
    bit timing_en = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.kernal_we) begin
            if (int'(bus.k_addr) != kwe_cnt % (CD*CD)) addr_bad++;
            kwe_cnt++;
        end
        if (bus.matrix_we) begin
            if (int'(bus.m_addr) != mwe_cnt % (MD*MD)) addr_bad++;
            mwe_cnt++;
        end
        if (bus.mac_clr !== (bus.mac_en && bus.k_addr == '0)) clr_bad++;
        if (bus.done) done_cnt++;
        if ((bus.done && !bus.busy) || (bus.done && prev_done) || (prev_done && !bus.done && bus.busy))
            db_bad++;
        if (mon_job != job_id) begin
            mon_job   = job_id;
            last_rise = -1;
        end
        if (bus.out_valid && !prev_ov) begin
            rise_cnt++;
            if (timing_en && last_rise >= 0 && cyc - last_rise != CD*CD + 2) tim_bad++;
            last_rise = cyc;
        end
        prev_ov   = bus.out_valid;
        prev_done = bus.done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, 32'({bus.in_ready, bus.out_valid, bus.busy, bus.done,
                                bus.kernal_we, bus.matrix_we, bus.mac_en, bus.mac_clr}), 32'd0);
        chk({tag, "_addr"}, 32'({bus.k_addr, bus.m_addr}), 32'd0);
        chk({tag, "_odata"}, 32'(bus.out_data), 32'd0);
    endtask

    function automatic bit gap_of(input int mode, input int i);
        if (mode == 1) return i > 0;
        if (mode == 2) return $urandom_range(0, 1) == 1;
        return 1'b0;
    endfunction

    task automatic send_word(input data_t w, input bit gap, input bit st);
        int to;
        to = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.data_in  = w;
        bus.start    = st;
        while (!bus.in_ready && to < 50) begin
            tick();
            to++;
        end
        if (to >= 50) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.data_in  = '0;
    endtask

    // gap_mode: 0 back-to-back, 1 alternating, 2 random; st_ld pulses start mid matrix load
    task automatic load_job(input int gap_mode, input bit st_ld);
        int k0, m0;
        k0 = kwe_cnt;
        m0 = mwe_cnt;
        job_id++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < CD*CD; i++) send_word(k_in[i], gap_of(gap_mode, i), 1'b0);
        for (int i = 0; i < MD*MD; i++) send_word(m_in[i], gap_of(gap_mode, i), st_ld && i == 5);
        chk("in_ready_compute", 32'(bus.in_ready), 32'd0);
        chk("kwe_count", 32'(kwe_cnt - k0), CD*CD);
        chk("mwe_count", 32'(mwe_cnt - m0), MD*MD);
        chk("we_addr", 32'(addr_bad), 32'd0);
    endtask

    // bp_mode: 0 none, 1 20-cycle stall on 3rd result, 2 random stalls
    task automatic drain_job(input int bp_mode, input bit st_emit, input int n_stop);
        int to, stall, hold_bad, men_bad, d0, r0;
        data_t got;
        d0 = done_cnt;
        r0 = rise_cnt;
        for (int n = 0; n < n_stop; n++) begin
            to = 0;
            bus.out_ready = (bp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!bus.out_valid && to < 100) begin
                tick();
                to++;
                if (bp_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
            end
            chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
            got   = bus.out_data;
            stall = 0;
            if (bp_mode == 1 && n == 2) stall = 20;
            if (bp_mode == 2 && $urandom_range(0, 3) == 0) stall = $urandom_range(1, 8);
            if (stall > 0) begin
                hold_bad = 0;
                men_bad  = 0;
                bus.out_ready = 1'b0;
                bus.start     = st_emit;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    bus.start = 1'b0;
                    if (!bus.out_valid || bus.out_data !== got) hold_bad++;
                    if (bus.mac_en) men_bad++;
                end
                chk("bp_hold", 32'(hold_bad), 32'd0);
                chk("bp_mac_en", 32'(men_bad), 32'd0);
            end
            bus.out_ready = 1'b1;
            chk($sformatf("result_%0d", n), 32'(got), 32'(ref_out(n / OD, n % OD)));
            tick();
        end
        if (n_stop == NOUT) begin
            to = 0;
            while (bus.busy && to < 50) begin
                tick();
                to++;
            end
            chk("busy_end", 32'(bus.busy), 32'd0);
            chk("done_once", 32'(done_cnt - d0), 32'd1);
            chk("done_busy", 32'(db_bad), 32'd0);
            chk("out_rises", 32'(rise_cnt - r0), NOUT);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #12;
        check_idle("reset");
        rst = 1'b1;
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // Nominal: kernel of ones, matrix[x][y] = 4x+y
        for (int i = 0; i < CD*CD; i++) k_in[i] = data_t'(1);
        for (int i = 0; i < MD*MD; i++) m_in[i] = data_t'(i);
        load_job(0, 1'b0);
        timing_en = 1'b1;
        drain_job(0, 1'b0, NOUT);
        timing_en = 1'b0;
        chk("timing", 32'(tim_bad), 32'd0);

        // Input gaps, start ignored in LOAD_M
        load_job(1, 1'b1);
        drain_job(0, 1'b0, NOUT);

        // Backpressure on 3rd result, start ignored in EMIT
        load_job(0, 1'b0);
        drain_job(1, 1'b1, NOUT);

        // Asynchronous reset in the middle of COMPUTE
        load_job(0, 1'b0);
        drain_job(0, 1'b0, 2);
        tick();
        tick();
        chk("mac_en_mid", 32'(bus.mac_en), 32'd1);
        rst = 1'b0;
        #2;
        check_idle("mid_reset");
        #5;
        rst = 1'b1;
        tick();
        k_in[0] = data_t'(1);
        for (int i = 1; i < CD*CD; i++) k_in[i] = '0;
        load_job(0, 1'b0);
        drain_job(0, 1'b0, NOUT);

        // Random data, gaps and backpressure
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < CD*CD; i++) k_in[i] = data_t'($urandom_range(0, 15));
            for (int i = 0; i < MD*MD; i++) m_in[i] = data_t'($urandom_range(0, 15));
            load_job(2, 1'b0);
            drain_job(2, 1'b0, NOUT);
        end

        chk("clr_align", 32'(clr_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
